// File: rtl/esfa_access_arbiter_pkg.sv
// Shared definitions for the ESFA access arbiter: FSM encoding, control-byte bit
// positions, data-word field offsets and response status layout.
package esfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESPOND = 3'd4
  } state_e;

  localparam int CTL_MUTATE = 0;
  localparam int CTL_META   = 1;
  localparam int CTL_WRITE  = 2;
  localparam int CTL_W      = 3;

  localparam int DATA_INDEX_LSB = 0;
  localparam int DATA_VALUE_LSB = 8;
  localparam int DATA_META_LSB  = 16;
  localparam int DATA_SEL_LSB   = 24;

  localparam int STATUS_OK     = 0;
  localparam int STATUS_CH_LSB = 4;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [7:0] data_field(input logic [31:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/esfa_access_arbiter_if.sv
// Host-side command/response bundle for the ESFA access arbiter.
//
// Handshake: a channel raises req_valid[i] with stable control/data and holds it
// until it sees its one-cycle req_ready[i] pulse; the arbiter then raises
// rsp_valid[i] with rsp_status/rsp_data stable until the channel pulses rsp_ack[i].
interface esfa_access_arbiter_if #(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]    req_valid;
  logic [8*NUM_REQ-1:0]  req_control;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [7:0]            rsp_status;
  logic [31:0]           rsp_data;
  logic [NUM_REQ-1:0]    rsp_ack;

  modport master (
    output req_valid, req_control, req_data, rsp_ack,
    input  req_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  req_valid, req_control, req_data, rsp_ack,
    output req_ready, rsp_valid, rsp_status, rsp_data
  );

endinterface

// File: rtl/esfa_rr_select.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// searching upward with wrap-around.
module esfa_rr_select
  import esfa_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic [IDX_W:0] cand;

  assign any_valid = |req;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/esfa_access_arbiter.sv
// Shares one ESFA engine among NUM_REQ host channels: round-robin grant, operand
// issue, fixed-latency wait, result capture and held response per command.
module esfa_access_arbiter
  import esfa_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ESFA_LATENCY = 2
) (
  input  logic                 masterClock,
  input  logic                 reset,
  esfa_access_arbiter_if.slave host,
  output logic [7:0]           esfa_new_index,
  output logic [7:0]           esfa_new_value,
  output logic [7:0]           esfa_metadata,
  output logic [7:0]           esfa_selector,
  output logic                 esfa_isMetadata,
  output logic                 esfa_willWrite,
  input  logic                 esfa_resultBool,
  input  logic [7:0]           esfa_resultValue,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic [CTL_W-1:0]      ctl_q, ctl_d;
  logic [31:0]           data_q, data_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]            rsp_status_q, rsp_status_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [7:0]            index_q, index_d;
  logic [7:0]            value_q, value_d;
  logic [7:0]            meta_q, meta_d;
  logic [7:0]            sel_q, sel_d;
  logic                  is_meta_q, is_meta_d;
  logic                  will_write_q, will_write_d;

  logic [IDX_W-1:0]      sel_idx;
  logic                  any_valid;

  esfa_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req       (host.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (sel_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    ctl_d        = ctl_q;
    data_d       = data_q;
    wait_cnt_d   = wait_cnt_q;
    req_ready_d  = '0;
    will_write_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    index_d      = index_q;
    value_d      = value_q;
    meta_d       = meta_q;
    sel_d        = sel_q;
    is_meta_d    = is_meta_q;

    case (state_q)
      ST_IDLE: begin
        rsp_valid_d = '0;
        if (any_valid) begin
          gnt_d                = sel_idx;
          req_ready_d[sel_idx] = 1'b1;
          ctl_d                = host.req_control[{sel_idx, 3'b000} +: CTL_W];
          data_d               = host.req_data[{sel_idx, 5'b00000} +: 32];
          state_d              = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Queries leave the engine operands alone so results reflect prior loads.
        if (ctl_q[CTL_MUTATE]) begin
          index_d      = data_field(data_q, DATA_INDEX_LSB);
          value_d      = data_field(data_q, DATA_VALUE_LSB);
          meta_d       = data_field(data_q, DATA_META_LSB);
          sel_d        = data_field(data_q, DATA_SEL_LSB);
          is_meta_d    = ctl_q[CTL_META];
          will_write_d = ctl_q[CTL_WRITE];
        end
        wait_cnt_d = WAIT_CNT_W'(ESFA_LATENCY - 1);
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      ST_CAPTURE: begin
        rsp_status_d = '0;
        rsp_status_d[STATUS_CH_LSB +: 4] = 4'(gnt_q);
        if (ctl_q[CTL_MUTATE]) begin
          rsp_status_d[STATUS_OK] = 1'b1;
          rsp_data_d              = '0;
        end else begin
          rsp_status_d[STATUS_OK] = esfa_resultBool;
          rsp_data_d              = {esfa_resultValue, 24'h000000};
        end
        rsp_valid_d        = '0;
        rsp_valid_d[gnt_q] = 1'b1;
        state_d            = ST_RESPOND;
      end

      ST_RESPOND: begin
        if (host.rsp_ack[gnt_q]) begin
          rsp_valid_d = '0;
          if (32'(gnt_q) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_q + 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      ctl_q        <= '0;
      data_q       <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      index_q      <= '0;
      value_q      <= '0;
      meta_q       <= '0;
      sel_q        <= '0;
      is_meta_q    <= 1'b0;
      will_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      ctl_q        <= ctl_d;
      data_q       <= data_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      index_q      <= index_d;
      value_q      <= value_d;
      meta_q       <= meta_d;
      sel_q        <= sel_d;
      is_meta_q    <= is_meta_d;
      will_write_q <= will_write_d;
    end
  end

  assign host.req_ready  = req_ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_status = rsp_status_q;
  assign host.rsp_data   = rsp_data_q;

  assign esfa_new_index  = index_q;
  assign esfa_new_value  = value_q;
  assign esfa_metadata   = meta_q;
  assign esfa_selector   = sel_q;
  assign esfa_isMetadata = is_meta_q;
  assign esfa_willWrite  = will_write_q;

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
